// File: rtl/lr35902_oam_dma_if.sv
// Bus bundle between the OAM DMA engine and the surrounding video top:
// FF46 register access, source read port and OAM write port.
interface lr35902_oam_dma_if;
  logic [7:0]  reg_din;
  logic        reg_write;
  logic [7:0]  reg_dout;
  logic [15:0] adr_rd;
  logic        rd;
  logic [7:0]  data_in;
  logic [7:0]  adr_wr;
  logic        wr;
  logic [7:0]  data_out;
  logic        active;
  logic        drv_ext;

  modport master (
    input  reg_din, reg_write, data_in,
    output reg_dout, adr_rd, rd, adr_wr, wr, data_out, active, drv_ext
  );

  modport slave (
    output reg_din, reg_write, data_in,
    input  reg_dout, adr_rd, rd, adr_wr, wr, data_out, active, drv_ext
  );
endinterface

// File: rtl/lr35902_oam_dma.sv
// OAM DMA engine: a write to FF46 copies LEN bytes from a source page into OAM,
// four clocks per byte (three read clocks, one OAM write clock).
module lr35902_oam_dma #(
  parameter int unsigned LEN          = 160,
  parameter int unsigned START_CYCLES = 4
) (
  input logic                 clk,
  input logic                 reset,
  lr35902_oam_dma_if.master   bus
);

  localparam int unsigned CW = $clog2(START_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StStart, StXfer} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [7:0]     idx_q, idx_d;
  logic [1:0]     ph_q, ph_d;
  logic [7:0]     base_q, base_d;
  logic [7:0]     data_q, data_d;
  logic           active_q, active_d;
  logic [7:0]     page;

  // Pages E0-FF are the echo of WRAM C0-DF.
  assign page = (base_q >= 8'hE0) ? (base_q - 8'h20) : base_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    ph_d    = ph_q;
    base_d  = base_q;
    data_d  = data_q;
    unique case (state_q)
      StStart: begin
        if (cnt_q == CW'(START_CYCLES)) begin
          state_d = StXfer;
          idx_d   = 8'd0;
          ph_d    = 2'd0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StXfer: begin
        if (ph_q == 2'd2) data_d = bus.data_in;
        if (ph_q == 2'd3) begin
          if (idx_q == 8'(LEN - 1)) begin
            state_d = StIdle;
          end else begin
            idx_d = idx_q + 8'd1;
            ph_d  = 2'd0;
          end
        end else begin
          ph_d = ph_q + 2'd1;
        end
      end
      default: ;
    endcase
    // A register write restarts from any state, abandoning any byte in flight.
    if (bus.reg_write) begin
      base_d  = bus.reg_din;
      state_d = StStart;
      cnt_d   = '0;
    end
    unique case (state_d)
      StXfer:  active_d = 1'b1;
      StStart: active_d = active_q;
      default: active_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= 8'd0;
      ph_q     <= 2'd0;
      base_q   <= 8'd0;
      data_q   <= 8'd0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      ph_q     <= ph_d;
      base_q   <= base_d;
      data_q   <= data_d;
      active_q <= active_d;
    end
  end

  assign bus.reg_dout = base_q;
  assign bus.adr_rd   = {page, idx_q};
  assign bus.rd       = (state_q == StXfer) && (ph_q != 2'd3);
  assign bus.wr       = (state_q == StXfer) && (ph_q == 2'd3);
  assign bus.adr_wr   = idx_q;
  assign bus.data_out = data_q;
  assign bus.active   = active_q;
  // VRAM (80-9F) is read internally, so the external pins stay released.
  assign bus.drv_ext  = active_q && (page[7:5] != 3'b100);

endmodule

// File: tb/tb_lr35902_oam_dma.sv
// Directed bench for lr35902_oam_dma: full transfers, page mapping, restart and reset.
module tb_lr35902_oam_dma;
  localparam int LEN = 160;
  localparam int START_CYCLES = 4;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  lr35902_oam_dma_if bus ();

  lr35902_oam_dma #(
    .LEN          (LEN),
    .START_CYCLES (START_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Source memory model: byte at address A is A[7:0] ^ 5A.
  assign bus.data_in = bus.adr_rd[7:0] ^ 8'h5A;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Call at a negedge; the following posedge is the write edge.
  task automatic start_write(input logic [7:0] val);
    bus.reg_din   = val;
    bus.reg_write = 1'b1;
  endtask

  task automatic check_xfer(input logic [7:0] page, input logic drv, input logic act_start,
                            input int stop_j, input string name);
    int          wr_cnt;
    int          act_cnt;
    logic [7:0]  i;
    logic [1:0]  p;
    logic [19:0] got;
    logic [19:0] exp;
    wr_cnt  = 0;
    act_cnt = 0;
    for (int k = 0; k < START_CYCLES + 1; k++) begin
      @(negedge clk);
      bus.reg_write = 1'b0;
      total++;
      if ({bus.active, bus.rd, bus.wr, bus.drv_ext} !== {act_start, 2'b00, act_start & drv}) begin
        bad++;
        $display("FAIL %s start k=%0d got act/rd/wr/drv=%b exp=%b", name, k,
                 {bus.active, bus.rd, bus.wr, bus.drv_ext}, {act_start, 2'b00, act_start & drv});
      end
    end
    for (int j = 0; j < stop_j; j++) begin
      @(negedge clk);
      bus.reg_write = 1'b0;
      i   = 8'(j / 4);
      p   = 2'(j % 4);
      exp = {1'b1, p != 2'd3, p == 2'd3, drv, page, i};
      got = {bus.active, bus.rd, bus.wr, bus.drv_ext, bus.adr_rd};
      if (bus.wr) wr_cnt++;
      if (bus.active) act_cnt++;
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL %s xfer j=%0d got=%h exp=%h", name, j, got, exp);
      end
      if (p == 2'd3) begin
        total++;
        if ({bus.adr_wr, bus.data_out} !== {i, i ^ 8'h5A}) begin
          bad++;
          $display("FAIL %s oam_wr i=%0d got=%h exp=%h", name, i, {bus.adr_wr, bus.data_out},
                   {i, i ^ 8'h5A});
        end
      end
    end
    if (stop_j == 4 * LEN) begin
      total++;
      if (wr_cnt !== LEN) begin
        bad++;
        $display("FAIL %s wr_count got=%0d exp=%0d", name, wr_cnt, LEN);
      end
      total++;
      if (act_cnt !== 4 * LEN) begin
        bad++;
        $display("FAIL %s active_count got=%0d exp=%0d", name, act_cnt, 4 * LEN);
      end
      @(negedge clk);
      total++;
      if ({bus.active, bus.rd, bus.wr, bus.drv_ext} !== 4'b0000) begin
        bad++;
        $display("FAIL %s idle_after got=%b exp=0000", name,
                 {bus.active, bus.rd, bus.wr, bus.drv_ext});
      end
    end
  endtask

  task automatic check_zero(input string name);
    total++;
    if ({bus.active, bus.rd, bus.wr, bus.drv_ext, bus.reg_dout, bus.adr_rd, bus.adr_wr,
         bus.data_out} !== 44'h0) begin
      bad++;
      $display("FAIL %s got act/rd/wr/drv=%b dout=%h adr_rd=%h adr_wr=%h data=%h exp all 0", name,
               {bus.active, bus.rd, bus.wr, bus.drv_ext}, bus.reg_dout, bus.adr_rd, bus.adr_wr,
               bus.data_out);
    end
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.reg_write = 1'b0;
    bus.reg_din   = 8'h00;
    repeat (2) @(negedge clk);
    check_zero("reset_state");
    reset = 1'b0;
  endtask

  task automatic test_full(input logic [7:0] val, input logic [7:0] page, input logic drv,
                           input string name);
    start_write(val);
    check_xfer(page, drv, 1'b0, 4 * LEN, name);
    total++;
    if (bus.reg_dout !== val) begin
      bad++;
      $display("FAIL %s reg_dout got=%h exp=%h", name, bus.reg_dout, val);
    end
  endtask

  task automatic test_restart();
    start_write(8'hC0);
    check_xfer(8'hC0, 1'b1, 1'b0, 50 * 4 + 2, "restart_first");
    start_write(8'hD0);
    check_xfer(8'hD0, 1'b1, 1'b1, 4 * LEN, "restart_second");
  endtask

  task automatic test_reset_mid();
    start_write(8'hC0);
    check_xfer(8'hC0, 1'b1, 1'b0, 100 * 4 + 1, "reset_mid_pre");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_zero("reset_mid_abort");
    repeat (6) @(negedge clk);
    check_zero("reset_mid_idle");
    test_full(8'hC2, 8'hC2, 1'b1, "after_reset_c2");
  endtask

  task automatic test_reset_write();
    reset = 1'b1;
    start_write(8'hC3);
    @(negedge clk);
    reset         = 1'b0;
    bus.reg_write = 1'b0;
    check_zero("reset_write_same_edge");
    repeat (8) @(negedge clk);
    check_zero("reset_write_stays_idle");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    @(negedge clk);
    test_full(8'hC1, 8'hC1, 1'b1, "wram_c1");
    test_full(8'h80, 8'h80, 1'b0, "vram_80");
    test_full(8'hFE, 8'hDE, 1'b1, "echo_fe");
    test_restart();
    test_reset_mid();
    test_reset_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
